// File: rtl/bmp_gray_convert_if.sv
// Single-port RAM bus between the grayscale stage (master) and the frame RAM (slave).
interface bmp_gray_convert_if #(
   parameter int ADDR_WIDTH = 20,
   parameter int BYTE_WIDTH = 8
);
   logic                  RAM_ren;
   logic                  RAM_wen;
   logic [ADDR_WIDTH-1:0] RAM_addr;
   logic [BYTE_WIDTH-1:0] RAM_in;
   logic [BYTE_WIDTH-1:0] RAM_out;

   modport master (
      output RAM_ren, RAM_wen, RAM_addr, RAM_in,
      input  RAM_out
   );

   modport slave (
      input  RAM_ren, RAM_wen, RAM_addr, RAM_in,
      output RAM_out
   );
endinterface

// File: rtl/bmp_gray_convert.sv
// In-place BGR->gray conversion of a 24-bit BMP pixel array held in single-port RAM.
// Define GRAY_ROUND_EN for round-half-up instead of truncation.
module bmp_gray_convert #(
   parameter int ADDR_WIDTH = 20,
   parameter int BYTE_WIDTH = 8,
   parameter int HDR_SIZE   = 54,
   parameter int IMG_W      = 512,
   parameter int IMG_H      = 512
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   bmp_gray_convert_if.master ram,
   output logic               busy,
   output logic               done
);

   localparam int ROW_PAD = (4 - (3 * IMG_W) % 4) % 4;
   localparam int CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0]         COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_H - 1);
   localparam logic [ADDR_WIDTH-1:0] P_BASE   = ADDR_WIDTH'(HDR_SIZE);
   localparam logic [ADDR_WIDTH-1:0] P_PIX    = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] P_ROW    = ADDR_WIDTH'(3 + ROW_PAD);
   localparam logic [ADDR_WIDTH-1:0] OFS_G    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] OFS_R    = ADDR_WIDTH'(2);

   typedef enum logic [3:0] {
      IDLE, RD_B, RD_G, RD_R, CAP, CALC, WR_B, WR_G, WR_R, DONE
   } state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] p, p_n, addr, addr_n;
   logic [CW-1:0]         col, col_n;
   logic [RW-1:0]         row, row_n;
   logic                  ren, ren_n, wen, wen_n, busy_n, done_n;
   logic [BYTE_WIDTH-1:0] din, din_n, b, g, r, gray;
   logic [17:0]           acc;

   always_comb begin
      acc = 18'd77 * 18'(r) + 18'd150 * 18'(g) + 18'd29 * 18'(b);
`ifdef GRAY_ROUND_EN
      acc = acc + 18'd128;
`else
      acc = acc;
`endif
      gray = BYTE_WIDTH'(acc[15:8]);
   end

   // Next state and pointer first; the bus outputs are then decoded from the
   // next state and registered, so they are valid during the state they belong to.
   always_comb begin
      state_n = state;
      p_n     = p;
      col_n   = col;
      row_n   = row;
      case (state)
         IDLE: if (start) state_n = RD_B;
         RD_B: state_n = RD_G;
         RD_G: state_n = RD_R;
         RD_R: state_n = CAP;
         CAP:  state_n = CALC;
         CALC: state_n = WR_B;
         WR_B: state_n = WR_G;
         WR_G: state_n = WR_R;
         WR_R: begin
            if (col != COL_LAST) begin
               p_n     = p + P_PIX;
               col_n   = col + 1'b1;
               state_n = RD_B;
            end else if (row != ROW_LAST) begin
               p_n     = p + P_ROW;
               col_n   = '0;
               row_n   = row + 1'b1;
               state_n = RD_B;
            end else begin
               state_n = DONE;
            end
         end
         DONE: begin
            p_n     = P_BASE;
            col_n   = '0;
            row_n   = '0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      ren_n  = 1'b0;
      wen_n  = 1'b0;
      addr_n = '0;
      din_n  = '0;
      case (state_n)
         RD_B: begin ren_n = 1'b1; addr_n = p_n;         end
         RD_G: begin ren_n = 1'b1; addr_n = p_n + OFS_G; end
         RD_R: begin ren_n = 1'b1; addr_n = p_n + OFS_R; end
         WR_B: begin wen_n = 1'b1; addr_n = p_n;         din_n = gray; end
         WR_G: begin wen_n = 1'b1; addr_n = p_n + OFS_G; din_n = din;  end
         WR_R: begin wen_n = 1'b1; addr_n = p_n + OFS_R; din_n = din;  end
         default: ;
      endcase
      busy_n = (state_n != IDLE) && (state_n != DONE);
      done_n = (state_n == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         p     <= P_BASE;
         col   <= '0;
         row   <= '0;
         ren   <= 1'b0;
         wen   <= 1'b0;
         addr  <= '0;
         din   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         p     <= p_n;
         col   <= col_n;
         row   <= row_n;
         ren   <= ren_n;
         wen   <= wen_n;
         addr  <= addr_n;
         din   <= din_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   // Read data arrives the cycle after each read request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b <= '0;
         g <= '0;
         r <= '0;
      end else begin
         case (state)
            RD_G:    b <= ram.RAM_out;
            RD_R:    g <= ram.RAM_out;
            CAP:     r <= ram.RAM_out;
            default: ;
         endcase
      end
   end

   assign ram.RAM_ren  = ren;
   assign ram.RAM_wen  = wen;
   assign ram.RAM_addr = addr;
   assign ram.RAM_in   = din;

endmodule

// File: tb/tb_bmp_gray_convert.sv
// Directed bench: 3x2 image (3 pad bytes per row) in a 256-byte RAM model.
module tb_bmp_gray_convert;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic busy;
   logic done;

   int checks   = 0;
   int failures = 0;
   int rd_cnt, wr_cnt, bad_cnt, done_cnt;

   logic [7:0] mem [256];
   logic [7:0] pb  [6];
   logic [7:0] pg  [6];
   logic [7:0] pr  [6];
   logic [7:0] exp_gray [6];

   always #5 clk = ~clk;

   bmp_gray_convert_if #(.ADDR_WIDTH(8), .BYTE_WIDTH(8)) bus ();

   bmp_gray_convert #(
      .ADDR_WIDTH(8),
      .BYTE_WIDTH(8),
      .HDR_SIZE  (54),
      .IMG_W     (3),
      .IMG_H     (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .ram  (bus),
      .busy (busy),
      .done (done)
   );

   function automatic bit is_pixel(input logic [7:0] a);
      return (a >= 8'd54) && (a < 8'd78) && (((a - 8'd54) % 8'd12) < 8'd9);
   endfunction

   function automatic int pix_addr(input int k);
      return 54 + (k / 3) * 12 + (k % 3) * 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // RAM model: synchronous read, write-through storage, access bookkeeping
   always @(posedge clk) begin
      if (bus.RAM_ren) begin
         bus.RAM_out <= mem[bus.RAM_addr];
         rd_cnt++;
         if (!is_pixel(bus.RAM_addr)) bad_cnt++;
      end
      if (bus.RAM_wen) begin
         mem[bus.RAM_addr] = bus.RAM_in;
         wr_cnt++;
         if (!is_pixel(bus.RAM_addr)) bad_cnt++;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("ren_wen_excl", 32'(bus.RAM_ren && bus.RAM_wen), 0);
         if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 0);
         end
      end
   end

   task automatic load_image();
      for (int a = 0; a < 256; a++) begin
         if (a < 54)              mem[a] = 8'hA5;
         else if (a >= 78)        mem[a] = 8'h33;
         else if (!is_pixel(8'(a))) mem[a] = 8'hEE;
         else                     mem[a] = 8'h00;
      end
      for (int k = 0; k < 6; k++) begin
         mem[pix_addr(k)]     = pb[k];
         mem[pix_addr(k) + 1] = pg[k];
         mem[pix_addr(k) + 2] = pr[k];
      end
      rd_cnt   = 0;
      wr_cnt   = 0;
      bad_cnt  = 0;
      done_cnt = 0;
   endtask

   task automatic verify_image(input string tag);
      int hdr_bad, pad_bad;
      hdr_bad = 0;
      pad_bad = 0;
      for (int a = 0; a < 54; a++)
         if (mem[a] !== 8'hA5) hdr_bad++;
      for (int a = 54; a < 256; a++) begin
         if (a >= 78 && mem[a] !== 8'h33) pad_bad++;
         if (a < 78 && !is_pixel(8'(a)) && mem[a] !== 8'hEE) pad_bad++;
      end
      check({tag, "_hdr_bytes_changed"}, 32'(hdr_bad), 0);
      check({tag, "_pad_bytes_changed"}, 32'(pad_bad), 0);
      for (int k = 0; k < 6; k++)
         for (int j = 0; j < 3; j++)
            check($sformatf("%s_px%0d_byte%0d", tag, k, j),
                  32'(mem[pix_addr(k) + j]), 32'(exp_gray[k]));
      check({tag, "_reads"},      32'(rd_cnt),  18);
      check({tag, "_writes"},     32'(wr_cnt),  18);
      check({tag, "_bad_access"}, 32'(bad_cnt), 0);
   endtask

   // Drives a start pulse and follows the frame to done; cyc counts the start
   // cycle and the done cycle inclusively.
   task automatic run_frame(input string tag, input bit restart_mid);
      int cyc;
      bit seen;
      cyc  = 1;
      seen = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (i == 0) begin
            start = 1'b0;
            check({tag, "_busy_after_start"}, 32'(busy), 1);
            check({tag, "_first_ren"},        32'(bus.RAM_ren), 1);
            check({tag, "_first_addr"},       32'(bus.RAM_addr), 54);
         end
         if (i == 24) begin
            check({tag, "_row1_ren"},  32'(bus.RAM_ren), 1);
            check({tag, "_row1_addr"}, 32'(bus.RAM_addr), 66);
         end
         if (restart_mid && i == 20) start = 1'b1;
         if (restart_mid && i == 21) start = 1'b0;
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check({tag, "_done_timeout"}, 0, 1);
      else       check({tag, "_latency"}, 32'(cyc), 50);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 32'(done), 0);
      check({tag, "_idle_busy"},      32'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_pulses"}, 32'(done_cnt), 1);
      verify_image(tag);
   endtask

   initial begin
      bit found;
      pb = '{8'd0,   8'd255, 8'd0, 8'd10, 8'd200, 8'd0};
      pg = '{8'd0,   8'd255, 8'd0, 8'd20, 8'd100, 8'd255};
      pr = '{8'd255, 8'd255, 8'd0, 8'd30, 8'd50,  8'd0};
`ifdef GRAY_ROUND_EN
      exp_gray = '{8'd77, 8'd255, 8'd0, 8'd22, 8'd96, 8'd149};
`else
      exp_gray = '{8'd76, 8'd255, 8'd0, 8'd21, 8'd96, 8'd149};
`endif
      rst_n = 1'b0;
      start = 1'b0;
      bus.RAM_out = '0;
      load_image();
      repeat (2) @(negedge clk);
      check("rst_ren",  32'(bus.RAM_ren),  0);
      check("rst_wen",  32'(bus.RAM_wen),  0);
      check("rst_addr", 32'(bus.RAM_addr), 0);
      check("rst_in",   32'(bus.RAM_in),   0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      rst_n = 1'b1;

      run_frame("basic", 1'b0);

      load_image();
      run_frame("restart_ignored", 1'b1);

      // Abort during the first pixel's G write.
      load_image();
      found = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (bus.RAM_wen && bus.RAM_addr == 8'd55) begin
            found = 1;
            break;
         end
      end
      if (!found) check("abort_wr_g_timeout", 0, 1);
      rst_n = 1'b0;
      #1;
      check("abort_ren",  32'(bus.RAM_ren),  0);
      check("abort_wen",  32'(bus.RAM_wen),  0);
      check("abort_addr", 32'(bus.RAM_addr), 0);
      check("abort_in",   32'(bus.RAM_in),   0);
      check("abort_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
      check("abort_hold_wen",  32'(bus.RAM_wen), 0);
      check("abort_hold_busy", 32'(busy), 0);
      check("abort_b_written", 32'(mem[54]), 32'(exp_gray[0]));
      check("abort_g_kept",    32'(mem[55]), 0);
      check("abort_r_kept",    32'(mem[56]), 255);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 0);

      load_image();
      run_frame("after_abort", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
